two_output_demux_buf: RTL and testbench

//   Registered 1-to-2 demultiplexer with valid/ready handshakes; the inverse of the 2:1 select mux.

---
 rtl/two_output_demux_buf.sv | 124 ++++++++++++
 tb/tb_two_output_demux_buf.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/two_output_demux_buf.sv
// two_output_demux_buf
//   Registered 1-to-2 demultiplexer with valid/ready handshakes. One input word
//   goes to out1 (in_sel=0) or out2 (in_sel=1), each through its own one-entry
//   output register, so the two consumers can stall independently.
//   Each port also has a wrapping transfer counter for debug.
//
//   Port state table (identical for both ports):
//     state    | meaning
//     ST_EMPTY | register holds no word, outN_valid=0
//     ST_FULL  | register holds a word, outN_valid=1, data stable until drained
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   in_data/in_sel        input word and destination (0 -> out1, 1 -> out2)
//   in_valid/in_ready     input handshake
//   outN_data/outN_valid  held word and full flag for port N
//   outN_ready            port N consumer accepts
//   clr_cnt               synchronous clear of both counters
//   cnt1/cnt2             completed handshakes per port (wrapping)
module two_output_demux_buf #(
  parameter int BUS_WIDTH = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic                 in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BUS_WIDTH-1:0] out1_data,
  output logic                 out1_valid,
  input  logic                 out1_ready,
  output logic [BUS_WIDTH-1:0] out2_data,
  output logic                 out2_valid,
  input  logic                 out2_ready,
  input  logic                 clr_cnt,
  output logic [CNT_WIDTH-1:0] cnt1,
  output logic [CNT_WIDTH-1:0] cnt2
);

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  logic                 st1_q, st1_d;
  logic                 st2_q, st2_d;
  logic [BUS_WIDTH-1:0] data1_q, data1_d;
  logic [BUS_WIDTH-1:0] data2_q, data2_d;
  logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;
  logic [CNT_WIDTH-1:0] cnt2_q, cnt2_d;

  logic accept, acc1, acc2, fire1, fire2;

  // A port can take a word when it is empty or is draining this cycle.
  // Only the targeted port matters, so a stalled target blocks the input.
  assign in_ready = in_sel ? ((st2_q == ST_EMPTY) | out2_ready)
                           : ((st1_q == ST_EMPTY) | out1_ready);

  assign accept = in_valid & in_ready;
  assign acc1   = accept & ~in_sel;
  assign acc2   = accept & in_sel;
  assign fire1  = (st1_q == ST_FULL) & out1_ready;
  assign fire2  = (st2_q == ST_FULL) & out2_ready;

  always_comb begin
    st1_d   = st1_q;
    data1_d = data1_q;
    if (acc1) begin
      st1_d   = ST_FULL;
      data1_d = in_data;
    end else if (fire1) begin
      st1_d   = ST_EMPTY;
    end
  end

  always_comb begin
    st2_d   = st2_q;
    data2_d = data2_q;
    if (acc2) begin
      st2_d   = ST_FULL;
      data2_d = in_data;
    end else if (fire2) begin
      st2_d   = ST_EMPTY;
    end
  end

  // Clear takes priority over a same-cycle handshake.
  always_comb begin
    cnt1_d = cnt1_q;
    cnt2_d = cnt2_q;
    if (clr_cnt) begin
      cnt1_d = '0;
      cnt2_d = '0;
    end else begin
      if (fire1) cnt1_d = cnt1_q + CNT_WIDTH'(1);
      if (fire2) cnt2_d = cnt2_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st1_q   <= ST_EMPTY;
      st2_q   <= ST_EMPTY;
      data1_q <= '0;
      data2_q <= '0;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
    end else begin
      st1_q   <= st1_d;
      st2_q   <= st2_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
    end
  end

  assign out1_valid = (st1_q == ST_FULL);
  assign out2_valid = (st2_q == ST_FULL);
  assign out1_data  = data1_q;
  assign out2_data  = data2_q;
  assign cnt1       = cnt1_q;
  assign cnt2       = cnt2_q;

endmodule

// File: tb/tb_two_output_demux_buf.sv
// Testbench for two_output_demux_buf: directed steps with per-port scoreboards.
module tb_two_output_demux_buf;

  logic       clk;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out1_data;
  logic       out1_valid;
  logic       out1_ready;
  logic [7:0] out2_data;
  logic       out2_valid;
  logic       out2_ready;
  logic       clr_cnt;
  logic [7:0] cnt1;
  logic [7:0] cnt2;

  int checks = 0;
  int errors = 0;
  int stall_cycles = 0;

  logic [7:0] q1[$];
  logic [7:0] q2[$];

  two_output_demux_buf #(.BUS_WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(out2_ready),
    .clr_cnt(clr_cnt), .cnt1(cnt1), .cnt2(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pops: each completed output handshake must match the oldest sent word.
  always @(negedge clk) begin
    if (reset_n && out1_valid && out1_ready) begin
      checks++;
      assert (q1.size() > 0) else begin
        errors++;
        $error("FAIL out1_unexpected observed=%0h expected=none", out1_data);
      end
      if (q1.size() > 0) check("out1_order", 32'(out1_data), 32'(q1.pop_front()));
    end
    if (reset_n && out2_valid && out2_ready) begin
      checks++;
      assert (q2.size() > 0) else begin
        errors++;
        $error("FAIL out2_unexpected observed=%0h expected=none", out2_data);
      end
      if (q2.size() > 0) check("out2_order", 32'(out2_data), 32'(q2.pop_front()));
    end
  end

  // Drive a word, wait (bounded) for in_ready, push expectation, step past the edge.
  // in_valid is left high so consecutive calls run back-to-back.
  task automatic send(input logic [7:0] d, input logic sel);
    int waits;
    in_data  = d;
    in_sel   = sel;
    in_valid = 1'b1;
    waits    = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      stall_cycles++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed=stalled expected=in_ready");
    end else if (sel) q2.push_back(d);
    else q1.push_back(d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_counters();
    in_valid = 1'b0;
    clr_cnt  = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt  = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    in_data    = '0;
    in_sel     = 1'b0;
    in_valid   = 1'b0;
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    clr_cnt    = 1'b0;
    #2;
    check("rst_out1_valid", 32'(out1_valid), 32'd0);
    check("rst_out2_valid", 32'(out2_valid), 32'd0);
    check("rst_out1_data", 32'(out1_data), 32'd0);
    check("rst_cnt1", 32'(cnt1), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);

    // Routing
    send(8'hA5, 1'b0);
    check("route_out1_valid", 32'(out1_valid), 32'd1);
    check("route_out1_data", 32'(out1_data), 32'hA5);
    send(8'h3C, 1'b1);
    check("route_out2_valid", 32'(out2_valid), 32'd1);
    check("route_out2_data", 32'(out2_data), 32'h3C);
    idle(2);
    check("route_cnt1", 32'(cnt1), 32'd1);
    check("route_cnt2", 32'(cnt2), 32'd1);

    // Stall on out2 blocks input
    out2_ready = 1'b0;
    send(8'h11, 1'b1);
    in_data  = 8'h22;
    in_sel   = 1'b1;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out2_hold", 32'(out2_data), 32'h11);
    end
    @(posedge clk);
    #1;
    out2_ready = 1'b1;
    send(8'h22, 1'b1);
    check("stall_out2_next", 32'(out2_data), 32'h22);
    idle(2);

    // Independence: out2 stalled, out1 still accepts
    out2_ready = 1'b0;
    send(8'h55, 1'b1);
    send(8'h66, 1'b0);
    check("indep_out1_data", 32'(out1_data), 32'h66);
    check("indep_out2_data", 32'(out2_data), 32'h55);
    check("indep_out2_valid", 32'(out2_valid), 32'd1);
    idle(1);
    out2_ready = 1'b1;
    idle(2);

    // Throughput
    clear_counters();
    check("clr_cnt1", 32'(cnt1), 32'd0);
    check("clr_cnt2", 32'(cnt2), 32'd0);
    stall_cycles = 0;
    for (int i = 0; i < 16; i++) send(8'(8'h80 + i), 1'b0);
    idle(2);
    check("tput_no_stall", 32'(stall_cycles), 32'd0);
    check("tput_cnt1", 32'(cnt1), 32'd16);

    // Counter wrap
    clear_counters();
    for (int i = 0; i < 255; i++) send(8'(i), 1'b0);
    idle(2);
    check("wrap_cnt1_255", 32'(cnt1), 32'd255);
    send(8'hFE, 1'b0);
    idle(2);
    check("wrap_cnt1_0", 32'(cnt1), 32'd0);
    for (int i = 0; i < 3; i++) send(8'(8'h40 + i), 1'b0);
    idle(2);
    check("wrap_cnt1_3", 32'(cnt1), 32'd3);

    // Clear wins over same-cycle handshake
    out1_ready = 1'b0;
    send(8'h77, 1'b0);
    in_valid = 1'b0;
    check("clrhs_cnt1_pre", 32'(cnt1), 32'd3);
    out1_ready = 1'b1;
    clear_counters();
    check("clrhs_cnt1", 32'(cnt1), 32'd0);
    check("clrhs_out1_valid", 32'(out1_valid), 32'd0);

    // Async reset mid-stream with out1 full
    send(8'h44, 1'b1);
    idle(2);
    check("prerst_cnt2", 32'(cnt2), 32'd1);
    out1_ready = 1'b0;
    send(8'h99, 1'b0);
    in_valid = 1'b0;
    check("prerst_out1_valid", 32'(out1_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    q1.delete();
    q2.delete();
    #1;
    check("mrst_out1_valid", 32'(out1_valid), 32'd0);
    check("mrst_out1_data", 32'(out1_data), 32'd0);
    check("mrst_cnt1", 32'(cnt1), 32'd0);
    check("mrst_cnt2", 32'(cnt2), 32'd0);
    @(posedge clk);
    #1;
    reset_n    = 1'b1;
    out1_ready = 1'b1;
    idle(2);
    check("post_rst_out1_valid", 32'(out1_valid), 32'd0);
    check("post_rst_cnt1", 32'(cnt1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
